fast_sequencer: RTL and testbench

FAST_SEQUENCER -- requirements
Module: fast_sequencer

---
 rtl/fast_pkg.sv | 39 +++
 rtl/fast_sequencer_if.sv | 37 +++
 rtl/fast_watchdog.sv | 38 +++
 rtl/fast_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fast_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fast_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fast_pkg
// Purpose  : Shared definitions for the fast sequencer. Holds the FSM state
//            encoding, the run status codes and the parameter defaults.
// Revision : 1.0 - initial release
// ============================================================================
package fast_pkg;

    // Sequencer states. The binary encoding is fixed so that debug taps and
    // register dumps decode the same way on every build.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_NORM   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Run outcome reported on status. It is held until the next start.
    typedef enum logic [1:0] {
        STAT_NONE    = 2'b00,
        STAT_CONV    = 2'b01,
        STAT_LIMIT   = 2'b10,
        STAT_TIMEOUT = 2'b11
    } status_t;

    // Parameter defaults.
    localparam int c_MAX_ITER_DEF = 16;
    localparam int c_START_TO_DEF = 4;
    localparam int c_RUN_TO_DEF   = 200;

    // Width of the watchdog counter and of the iteration counter.
    localparam int c_CNT_W = 8;

endpackage : fast_pkg
`default_nettype wire

// File: rtl/fast_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fast_sequencer_if
// Purpose  : Handshake bundle between the fast sequencer (slave side) and its
//            environment: the datapath controller and the convergence checker.
// Revision : 1.0 - initial release
// ============================================================================
interface fast_sequencer_if;
    import fast_pkg::*;

    logic                 start;
    logic                 fast_busy;
    logic                 conv_valid;
    logic                 conv_hit;
    logic                 go_fast;
    logic                 en_norm;
    logic                 en_conv;
    logic [c_CNT_W-1:0]   iter_cnt;
    logic                 busy;
    logic                 done;
    logic [1:0]           status;

    // Environment side: drives requests and datapath feedback.
    modport master (
        output start, fast_busy, conv_valid, conv_hit,
        input  go_fast, en_norm, en_conv, iter_cnt, busy, done, status
    );

    // Sequencer side.
    modport slave (
        input  start, fast_busy, conv_valid, conv_hit,
        output go_fast, en_norm, en_conv, iter_cnt, busy, done, status
    );

endinterface : fast_sequencer_if
`default_nettype wire

// File: rtl/fast_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fast_watchdog
// Purpose  : Saturating cycle counter used for the launch and run timeouts.
//            expired is high during the cycle that would be the limit-th
//            enabled cycle, so the owner can leave the state on that edge.
// Revision : 1.0 - initial release
// ============================================================================
module fast_watchdog
    import fast_pkg::*;
(
    input  wire logic                 clk_fast,
    input  wire logic                 rst,
    input  wire logic                 clear,
    input  wire logic                 enable,
    input  wire logic [c_CNT_W-1:0]   limit,
    output logic                      expired
);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W:0]   w_cnt_plus1;

    // Count enabled cycles; clear wins over enable and the count sticks at all-ones.
    always_ff @(posedge clk_fast) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != {c_CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(c_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // One extra bit so the compare never wraps, even with a saturated count.
    assign w_cnt_plus1 = {1'b0, r_cnt} + {{c_CNT_W{1'b0}}, 1'b1};
    assign expired     = (w_cnt_plus1 >= {1'b0, limit});

endmodule : fast_watchdog
`default_nettype wire

// File: rtl/fast_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fast_sequencer
// Purpose  : Controls a fixed-point iteration loop. Each iteration launches
//            the datapath, waits for it to finish, pulses normalisation, then
//            consults the convergence checker. A run ends on convergence, on
//            the iteration limit, or on a launch/run timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fast_sequencer
    import fast_pkg::*;
#(
    parameter int MAX_ITER = c_MAX_ITER_DEF,
    parameter int START_TO = c_START_TO_DEF,
    parameter int RUN_TO   = c_RUN_TO_DEF
) (
    input  wire logic          clk_fast,
    input  wire logic          rst,
    fast_sequencer_if.slave    bus
);

    localparam logic [c_CNT_W-1:0] c_MAX_ITER = c_CNT_W'(MAX_ITER);
    localparam logic [c_CNT_W-1:0] c_START_TO = c_CNT_W'(START_TO);
    localparam logic [c_CNT_W-1:0] c_RUN_TO   = c_CNT_W'(RUN_TO);

    state_t              r_state;
    state_t              w_next;
    logic                w_status_set;
    status_t             w_status_code;

    logic                r_go_fast;
    logic                r_en_norm;
    logic                r_en_conv;
    logic                r_done;
    logic [c_CNT_W-1:0]  r_iter_cnt;
    status_t             r_status;

    logic                w_wd_clear;
    logic                w_wd_en;
    logic [c_CNT_W-1:0]  w_wd_limit;
    logic                w_wd_exp;

    // Watchdog restarts on every state change; it only advances while the
    // datapath is overdue (LAUNCH) or still busy (RUN).
    assign w_wd_clear = (w_next != r_state);
    assign w_wd_en    = ((r_state == S_LAUNCH) && !bus.fast_busy) ||
                        ((r_state == S_RUN)    &&  bus.fast_busy);
    assign w_wd_limit = (r_state == S_RUN) ? c_RUN_TO : c_START_TO;

    fast_watchdog u_watchdog (
        .clk_fast (clk_fast),
        .rst      (rst),
        .clear    (w_wd_clear),
        .enable   (w_wd_en),
        .limit    (w_wd_limit),
        .expired  (w_wd_exp)
    );

    // State register.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and the status code to latch when a run ends.
    always_comb begin
        w_next        = r_state;
        w_status_set  = 1'b0;
        w_status_code = STAT_NONE;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (bus.fast_busy) begin
                    w_next = S_RUN;
                end else if (w_wd_exp) begin
                    w_next        = S_DONE;
                    w_status_set  = 1'b1;
                    w_status_code = STAT_TIMEOUT;
                end
            end
            S_RUN: begin
                if (!bus.fast_busy) begin
                    w_next = S_NORM;
                end else if (w_wd_exp) begin
                    w_next        = S_DONE;
                    w_status_set  = 1'b1;
                    w_status_code = STAT_TIMEOUT;
                end
            end
            S_NORM: begin
                w_next = S_CHECK;
            end
            S_CHECK: begin
                // Convergence takes priority over the iteration limit.
                if (bus.conv_valid) begin
                    if (bus.conv_hit) begin
                        w_next        = S_DONE;
                        w_status_set  = 1'b1;
                        w_status_code = STAT_CONV;
                    end else if (r_iter_cnt == c_MAX_ITER) begin
                        w_next        = S_DONE;
                        w_status_set  = 1'b1;
                        w_status_code = STAT_LIMIT;
                    end else begin
                        w_next = S_LAUNCH;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the state being entered so each one
    // lines up exactly with its state. go_fast falls on the edge that leaves
    // RUN, which keeps it low through NORM and CHECK.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_go_fast  <= 1'b0;
            r_en_norm  <= 1'b0;
            r_en_conv  <= 1'b0;
            r_done     <= 1'b0;
            r_iter_cnt <= '0;
            r_status   <= STAT_NONE;
        end else begin
            r_go_fast <= (w_next == S_LAUNCH) || (w_next == S_RUN);
            r_en_norm <= (w_next == S_NORM);
            r_en_conv <= (w_next == S_CHECK);
            r_done    <= (w_next == S_DONE);

            if ((r_state == S_IDLE) && bus.start) begin
                r_iter_cnt <= '0;
                r_status   <= STAT_NONE;
            end else begin
                if ((r_state == S_NORM) && (r_iter_cnt < c_MAX_ITER)) begin
                    r_iter_cnt <= r_iter_cnt + {{(c_CNT_W-1){1'b0}}, 1'b1};
                end
                if (w_status_set) begin
                    r_status <= w_status_code;
                end
            end
        end
    end

    assign bus.go_fast  = r_go_fast;
    assign bus.en_norm  = r_en_norm;
    assign bus.en_conv  = r_en_conv;
    assign bus.done     = r_done;
    assign bus.iter_cnt = r_iter_cnt;
    assign bus.status   = r_status;
    assign bus.busy     = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule : fast_sequencer
`default_nettype wire

// File: tb/tb_fast_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fast_sequencer
// Purpose  : Self-checking bench for fast_sequencer with a datapath and
//            convergence-checker model and a queue of expected run results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fast_sequencer;
    import fast_pkg::*;

    localparam int TB_MAX_ITER = 3;

    typedef struct {
        logic [7:0] iter;
        logic [1:0] status;
    } exp_t;

    logic clk_fast = 1'b0;
    logic rst      = 1'b1;

    always #5 clk_fast = ~clk_fast;

    fast_sequencer_if bus();

    fast_sequencer #(
        .MAX_ITER (TB_MAX_ITER),
        .START_TO (4),
        .RUN_TO   (200)
    ) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .bus      (bus)
    );

    // Datapath / convergence model configuration (written by the test thread only).
    int dp_mode  = 0;   // 0 normal, 1 busy never rises, 2 busy stuck high
    int dp_lat   = 1;   // cycles of go_fast before busy rises
    int dp_len   = 5;   // cycles busy stays high in normal mode
    int conv_lat = 0;   // cycles of en_conv before conv_valid
    bit conv_hit_mode = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Datapath and convergence-checker model, driven just after each rising edge.
    int dp_cnt   = 0;
    int dp_phase = 0;
    int cv_cnt   = 0;
    initial begin
        bus.fast_busy  = 1'b0;
        bus.conv_valid = 1'b0;
        bus.conv_hit   = 1'b0;
        forever begin
            @(posedge clk_fast);
            #1;
            if (!bus.go_fast) begin
                bus.fast_busy = 1'b0;
                dp_cnt   = 0;
                dp_phase = 0;
            end else begin
                case (dp_phase)
                    0: begin
                        dp_cnt++;
                        if (dp_mode != 1 && dp_cnt >= dp_lat) begin
                            bus.fast_busy = 1'b1;
                            dp_phase = 1;
                            dp_cnt   = 0;
                        end
                    end
                    1: begin
                        dp_cnt++;
                        if (dp_mode == 0 && dp_cnt >= dp_len) begin
                            bus.fast_busy = 1'b0;
                            dp_phase = 2;
                        end
                    end
                    default: ;
                endcase
            end
            if (bus.en_conv) begin
                if (cv_cnt >= conv_lat) begin
                    bus.conv_valid = 1'b1;
                    bus.conv_hit   = conv_hit_mode;
                end else begin
                    bus.conv_valid = 1'b0;
                    bus.conv_hit   = 1'b0;
                end
                cv_cnt++;
            end else begin
                cv_cnt = 0;
                bus.conv_valid = 1'b0;
                bus.conv_hit   = 1'b0;
            end
        end
    end

    // Free-running event counters; tests take differences around a scenario.
    int   gf_rises    = 0;
    int   gf_high     = 0;
    int   done_pulses = 0;
    int   norm_cycles = 0;
    int   gap_viol    = 0;
    logic gf_prev     = 1'b0;
    always @(negedge clk_fast) begin
        if (bus.go_fast && !gf_prev) gf_rises <= gf_rises + 1;
        if (bus.go_fast)             gf_high  <= gf_high + 1;
        if (bus.done)                done_pulses <= done_pulses + 1;
        if (bus.en_norm)             norm_cycles <= norm_cycles + 1;
        if ((bus.en_norm || bus.en_conv) && bus.go_fast) gap_viol <= gap_viol + 1;
        gf_prev <= bus.go_fast;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_fast);
    endtask

    task automatic pulse_start;
        @(negedge clk_fast);
        bus.start = 1'b1;
        @(negedge clk_fast);
        bus.start = 1'b0;
    endtask

    // Wait for done and pop the matching expectation.
    task automatic collect(input int budget, output bit seen,
                           output logic [7:0] got_iter, output logic [1:0] got_st,
                           output exp_t e);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_fast);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        got_iter = bus.iter_cnt;
        got_st   = bus.status;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = '{iter: 8'hxx, status: 2'bxx};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        idle(3);
        checks++; if (bus.go_fast !== 1'b0)  begin errors++; $display("FAIL reset_go_fast got %b want 0", bus.go_fast); end
        checks++; if (bus.en_norm !== 1'b0)  begin errors++; $display("FAIL reset_en_norm got %b want 0", bus.en_norm); end
        checks++; if (bus.en_conv !== 1'b0)  begin errors++; $display("FAIL reset_en_conv got %b want 0", bus.en_conv); end
        checks++; if (bus.iter_cnt !== 8'd0) begin errors++; $display("FAIL reset_iter_cnt got %0d want 0", bus.iter_cnt); end
        checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.status !== 2'b00)  begin errors++; $display("FAIL reset_status got %b want 00", bus.status); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_converge;
        bit seen; logic [7:0] gi; logic [1:0] gs; exp_t e;
        int d0, r0, n0;
        dp_mode = 0; dp_lat = 1; dp_len = 133; conv_lat = 0; conv_hit_mode = 1'b1;
        d0 = done_pulses; r0 = gf_rises; n0 = norm_cycles;
        exp_q.push_back('{iter: 8'd1, status: 2'b01});
        pulse_start();
        collect(1000, seen, gi, gs, e);
        checks++; if (!seen) begin errors++; $display("FAIL converge_done no done pulse within budget"); end
        checks++; if (gi !== e.iter)   begin errors++; $display("FAIL converge_iter got %0d want %0d", gi, e.iter); end
        checks++; if (gs !== e.status) begin errors++; $display("FAIL converge_status got %b want %b", gs, e.status); end
        idle(5);
        checks++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL converge_done_count got %0d want 1", done_pulses - d0); end
        checks++; if (gf_rises - r0 != 1)    begin errors++; $display("FAIL converge_go_periods got %0d want 1", gf_rises - r0); end
        checks++; if (norm_cycles - n0 != 1) begin errors++; $display("FAIL converge_norm_cycles got %0d want 1", norm_cycles - n0); end
    endtask

    task automatic test_iter_limit;
        bit seen; logic [7:0] gi; logic [1:0] gs; exp_t e;
        int d0, r0, n0, g0;
        dp_mode = 0; dp_lat = 2; dp_len = 5; conv_lat = 1; conv_hit_mode = 1'b0;
        d0 = done_pulses; r0 = gf_rises; n0 = norm_cycles; g0 = gap_viol;
        exp_q.push_back('{iter: 8'(TB_MAX_ITER), status: 2'b10});
        pulse_start();
        collect(500, seen, gi, gs, e);
        checks++; if (!seen) begin errors++; $display("FAIL limit_done no done pulse within budget"); end
        checks++; if (gi !== e.iter)   begin errors++; $display("FAIL limit_iter got %0d want %0d", gi, e.iter); end
        checks++; if (gs !== e.status) begin errors++; $display("FAIL limit_status got %b want %b", gs, e.status); end
        idle(5);
        checks++; if (gf_rises - r0 != TB_MAX_ITER)    begin errors++; $display("FAIL limit_go_periods got %0d want %0d", gf_rises - r0, TB_MAX_ITER); end
        checks++; if (norm_cycles - n0 != TB_MAX_ITER) begin errors++; $display("FAIL limit_norm_cycles got %0d want %0d", norm_cycles - n0, TB_MAX_ITER); end
        checks++; if (gap_viol - g0 != 0)    begin errors++; $display("FAIL limit_go_gap got %0d overlaps want 0", gap_viol - g0); end
        checks++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL limit_done_count got %0d want 1", done_pulses - d0); end
        checks++; if (bus.iter_cnt !== 8'(TB_MAX_ITER)) begin errors++; $display("FAIL limit_iter_hold got %0d want %0d", bus.iter_cnt, TB_MAX_ITER); end
    endtask

    task automatic test_start_timeout;
        bit seen; logic [7:0] gi; logic [1:0] gs; exp_t e;
        int h0, d0;
        dp_mode = 1; conv_hit_mode = 1'b0;
        h0 = gf_high; d0 = done_pulses;
        exp_q.push_back('{iter: 8'd0, status: 2'b11});
        pulse_start();
        collect(100, seen, gi, gs, e);
        checks++; if (!seen) begin errors++; $display("FAIL start_to_done no done pulse within budget"); end
        checks++; if (gi !== e.iter)   begin errors++; $display("FAIL start_to_iter got %0d want %0d", gi, e.iter); end
        checks++; if (gs !== e.status) begin errors++; $display("FAIL start_to_status got %b want %b", gs, e.status); end
        idle(5);
        checks++; if (gf_high - h0 != 4)     begin errors++; $display("FAIL start_to_go_cycles got %0d want 4", gf_high - h0); end
        checks++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL start_to_done_count got %0d want 1", done_pulses - d0); end
    endtask

    task automatic test_run_timeout;
        bit seen; logic [7:0] gi; logic [1:0] gs; exp_t e;
        int h0;
        dp_mode = 2; dp_lat = 1;
        h0 = gf_high;
        exp_q.push_back('{iter: 8'd0, status: 2'b11});
        pulse_start();
        collect(1000, seen, gi, gs, e);
        checks++; if (!seen) begin errors++; $display("FAIL run_to_done no done pulse within budget"); end
        checks++; if (gi !== e.iter)   begin errors++; $display("FAIL run_to_iter got %0d want %0d", gi, e.iter); end
        checks++; if (gs !== e.status) begin errors++; $display("FAIL run_to_status got %b want %b", gs, e.status); end
        idle(5);
        // One LAUNCH cycle followed by 200 RUN cycles with busy high.
        checks++; if (gf_high - h0 != 201) begin errors++; $display("FAIL run_to_go_cycles got %0d want 201", gf_high - h0); end
        dp_mode = 0;
    endtask

    task automatic test_reset_midrun;
        bit seen; logic [7:0] gi; logic [1:0] gs; exp_t e;
        int d0;
        dp_mode = 0; dp_lat = 1; dp_len = 100; conv_lat = 0; conv_hit_mode = 1'b1;
        d0 = done_pulses;
        pulse_start();
        idle(20);
        checks++; if (bus.go_fast !== 1'b1) begin errors++; $display("FAIL midrun_running go_fast got %b want 1", bus.go_fast); end
        rst = 1'b1;
        @(posedge clk_fast);
        #1;
        checks++; if (bus.go_fast !== 1'b0) begin errors++; $display("FAIL midrun_go_fast got %b want 0", bus.go_fast); end
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL midrun_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL midrun_done got %b want 0", bus.done); end
        @(negedge clk_fast);
        rst = 1'b0;
        idle(5);
        checks++; if (done_pulses - d0 != 0) begin errors++; $display("FAIL midrun_no_done got %0d pulses want 0", done_pulses - d0); end
        dp_len = 7;
        exp_q.push_back('{iter: 8'd1, status: 2'b01});
        pulse_start();
        collect(200, seen, gi, gs, e);
        checks++; if (!seen) begin errors++; $display("FAIL midrun_restart_done no done pulse within budget"); end
        checks++; if (gi !== e.iter)   begin errors++; $display("FAIL midrun_restart_iter got %0d want %0d", gi, e.iter); end
        checks++; if (gs !== e.status) begin errors++; $display("FAIL midrun_restart_status got %b want %b", gs, e.status); end
        idle(3);
    endtask

    task automatic test_start_ignored;
        bit seen; logic [7:0] gi; logic [1:0] gs; exp_t e;
        int d0, r0, g0;
        dp_mode = 0; dp_lat = 1; dp_len = 6; conv_lat = 2; conv_hit_mode = 1'b0;
        d0 = done_pulses; r0 = gf_rises; g0 = gap_viol;
        exp_q.push_back('{iter: 8'(TB_MAX_ITER), status: 2'b10});
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_fast);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            bus.start = (bus.en_conv || (bus.go_fast && bus.fast_busy)) ? 1'b1 : 1'b0;
        end
        bus.start = 1'b0;
        gi = bus.iter_cnt;
        gs = bus.status;
        e  = exp_q.pop_front();
        checks++; if (!seen) begin errors++; $display("FAIL ignored_done no done pulse within budget"); end
        checks++; if (gi !== e.iter)   begin errors++; $display("FAIL ignored_iter got %0d want %0d", gi, e.iter); end
        checks++; if (gs !== e.status) begin errors++; $display("FAIL ignored_status got %b want %b", gs, e.status); end
        idle(6);
        checks++; if (gf_rises - r0 != TB_MAX_ITER) begin errors++; $display("FAIL ignored_go_periods got %0d want %0d", gf_rises - r0, TB_MAX_ITER); end
        checks++; if (gap_viol - g0 != 0)    begin errors++; $display("FAIL ignored_go_gap got %0d overlaps want 0", gap_viol - g0); end
        checks++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL ignored_done_count got %0d want 1", done_pulses - d0); end
        checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL ignored_idle_after busy got %b want 0", bus.busy); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_converge();
        test_iter_limit();
        test_start_timeout();
        test_run_timeout();
        test_reset_midrun();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fast_sequencer
`default_nettype wire
